// File: rtl/dendritic_compartment_mc.sv
// Time-multiplexed multi-channel dendritic compartment: one shared datapath sweeps
// N_CH channels per sample strobe. Define DENDRITIC_MC_SATURATE_EN to saturate comb/out.
//
// Ca2+ FSM (per channel):
//   state      | meaning
//   CA_IDLE    | waiting for apical depot to exceed ca_threshold
//   CA_PLATEAU | Ca2+ plateau active, cnt counts remaining sweeps
//   CA_REFRACT | refractory, threshold ignored, cnt counts remaining sweeps
module dendritic_compartment_mc #(
   parameter int WIDTH       = 18,
   parameter int FRAC        = 14,
   parameter int N_CH        = 4,
   parameter int CABLE_ALPHA = 410,
   parameter int CA_ALPHA    = 137,
   parameter int K_APICAL    = 4096,
   parameter int K_BAC       = 24576,
   parameter int BAC_THRESH  = 4096,
   parameter int PLATEAU_CYC = 120,
   parameter int REFRAC_CYC  = 40,
   parameter int BAC_WIN     = 20,
   localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clk_en,
   input  logic [N_CH*WIDTH-1:0]   basal_in,
   input  logic [N_CH*WIDTH-1:0]   apical_in,
   input  logic [WIDTH-1:0]        apical_gain,
   input  logic [WIDTH-1:0]        ca_threshold,
   input  logic                    overrun_clr,
   output logic                    busy,
   output logic                    out_valid,
   output logic [CH_W-1:0]         out_ch,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_ca_plateau,
   output logic                    out_bac,
   output logic                    done,
   output logic                    overrun
);

   localparam int P       = 2 * WIDTH;
   localparam int W1      = WIDTH + 1;
   localparam int CNT_MAX = (PLATEAU_CYC > REFRAC_CYC) ? PLATEAU_CYC : REFRAC_CYC;
   localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
   localparam int WIN_W   = (BAC_WIN > 0) ? $clog2(BAC_WIN + 1) : 1;

   localparam logic signed [P-1:0] CABLE_K = P'(CABLE_ALPHA);
   localparam logic signed [P-1:0] CA_K    = P'(CA_ALPHA);
   localparam logic signed [P-1:0] KAP     = P'(K_APICAL);
   localparam logic signed [P-1:0] KBAC    = P'(K_BAC);
   localparam logic signed [P-1:0] ONE_P   = P'(2 ** FRAC);
   localparam logic signed [P-1:0] BT_P    = P'(BAC_THRESH);
   localparam logic signed [P-1:0] NBT_P   = P'(-BAC_THRESH);
   localparam logic signed [WIDTH-1:0] ONE_W = WIDTH'(2 ** FRAC);

   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);
   localparam logic [CNT_W-1:0] PL_LOAD  = CNT_W'((PLATEAU_CYC > 0) ? PLATEAU_CYC - 1 : 0);
   localparam logic [CNT_W-1:0] RF_LOAD  = CNT_W'((REFRAC_CYC > 0) ? REFRAC_CYC - 1 : 0);
   localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(BAC_WIN);

`ifdef DENDRITIC_MC_SATURATE_EN
   localparam logic signed [P-1:0] MAX_P = P'((2 ** (WIDTH - 1)) - 1);
   localparam logic signed [P-1:0] MIN_P = P'(-(2 ** (WIDTH - 1)));

   function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [P-1:0] x);
      if (x > MAX_P)      return WIDTH'(MAX_P);
      else if (x < MIN_P) return WIDTH'(MIN_P);
      else                return WIDTH'(x);
   endfunction
`endif

   typedef enum logic [1:0] {
      CA_IDLE    = 2'd0,
      CA_PLATEAU = 2'd1,
      CA_REFRACT = 2'd2
   } ca_state_t;

   // Snapshot taken at sweep start so inputs may change mid-sweep.
   logic signed [WIDTH-1:0] basal_q  [N_CH];
   logic signed [WIDTH-1:0] apical_q [N_CH];
   logic signed [WIDTH-1:0] gain_q;
   logic signed [WIDTH-1:0] thr_q;

   logic signed [WIDTH-1:0] depot_q [N_CH];
   logic signed [WIDTH-1:0] ca_q    [N_CH];
   ca_state_t               st_q    [N_CH];
   logic [CNT_W-1:0]        cnt_q   [N_CH];
   logic [WIN_W-1:0]        win_q   [N_CH];

   logic                    busy_q;
   logic [CH_W-1:0]         ch_q;
   logic                    overrun_q;
   logic                    out_valid_q;
   logic [CH_W-1:0]         out_ch_q;
   logic [WIDTH-1:0]        out_data_q;
   logic                    plat_q;
   logic                    bac_q;
   logic                    done_q;

   logic signed [WIDTH-1:0] basal_c, apical_c, depot_c, ca_c, ca_use;
   ca_state_t               st_c, st_d;
   logic [CNT_W-1:0]        cnt_c, cnt_d;
   logic [WIN_W-1:0]        win_c, win_d;
   logic signed [WIDTH-1:0] a_w, ca_tgt, comb_w;
   logic signed [W1-1:0]    diff_dep, diff_ca;
   logic signed [WIDTH-1:0] depot_d, ca_d, out_d;
   logic signed [P-1:0]     ap_term, gain_sel;
   logic                    basal_active, bac_d;

   always_comb begin
      basal_c  = basal_q[ch_q];
      apical_c = apical_q[ch_q];
      depot_c  = depot_q[ch_q];
      ca_c     = ca_q[ch_q];
      st_c     = st_q[ch_q];
      cnt_c    = cnt_q[ch_q];
      win_c    = win_q[ch_q];

      a_w      = WIDTH'((P'(apical_c) * P'(gain_q)) >>> FRAC);
      diff_dep = W1'(a_w) - W1'(depot_c);
      depot_d  = depot_c + WIDTH'((P'(diff_dep) * CABLE_K) >>> FRAC);

      ca_tgt   = (st_c == CA_PLATEAU) ? ONE_W : '0;
      diff_ca  = W1'(ca_tgt) - W1'(ca_c);
      ca_d     = ca_c + WIDTH'((P'(diff_ca) * CA_K) >>> FRAC);

      basal_active = (P'(basal_c) > BT_P) || (P'(basal_c) < NBT_P);
      bac_d        = (st_c == CA_PLATEAU) && (basal_active || (win_c != '0));
      if (basal_active)     win_d = WIN_LOAD;
      else if (win_c != '0) win_d = win_c - 1'b1;
      else                  win_d = win_c;

      st_d  = st_c;
      cnt_d = cnt_c;
      case (st_c)
         CA_IDLE: begin
            if (depot_c > thr_q) begin
               if (PLATEAU_CYC > 0) begin
                  st_d  = CA_PLATEAU;
                  cnt_d = PL_LOAD;
               end else if (REFRAC_CYC > 0) begin
                  st_d  = CA_REFRACT;
                  cnt_d = RF_LOAD;
               end
            end
         end
         CA_PLATEAU: begin
            if (cnt_c == '0) begin
               if (REFRAC_CYC > 0) begin
                  st_d  = CA_REFRACT;
                  cnt_d = RF_LOAD;
               end else begin
                  st_d = CA_IDLE;
               end
            end else begin
               cnt_d = cnt_c - 1'b1;
            end
         end
         CA_REFRACT: begin
            if (cnt_c == '0) st_d = CA_IDLE;
            else             cnt_d = cnt_c - 1'b1;
         end
         default: begin
            st_d  = CA_IDLE;
            cnt_d = '0;
         end
      endcase

      ca_use   = ca_c[WIDTH-1] ? '0 : ca_c;
      ap_term  = (P'(ca_use) * KAP) >>> FRAC;
      gain_sel = bac_d ? KBAC : ONE_P;
`ifdef DENDRITIC_MC_SATURATE_EN
      comb_w   = sat_w(P'(basal_c) + ap_term);
      out_d    = sat_w((P'(comb_w) * gain_sel) >>> FRAC);
`else
      comb_w   = WIDTH'(P'(basal_c) + ap_term);
      out_d    = WIDTH'((P'(comb_w) * gain_sel) >>> FRAC);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            basal_q[i]  <= '0;
            apical_q[i] <= '0;
            depot_q[i]  <= '0;
            ca_q[i]     <= '0;
            st_q[i]     <= CA_IDLE;
            cnt_q[i]    <= '0;
            win_q[i]    <= '0;
         end
         gain_q      <= '0;
         thr_q       <= '0;
         busy_q      <= 1'b0;
         ch_q        <= '0;
         overrun_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_data_q  <= '0;
         plat_q      <= 1'b0;
         bac_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_data_q  <= '0;
         plat_q      <= 1'b0;
         bac_q       <= 1'b0;
         done_q      <= 1'b0;

         if (clk_en && busy_q) overrun_q <= 1'b1;
         else if (overrun_clr) overrun_q <= 1'b0;

         if (!busy_q) begin
            if (clk_en) begin
               for (int i = 0; i < N_CH; i++) begin
                  basal_q[i]  <= basal_in[i*WIDTH +: WIDTH];
                  apical_q[i] <= apical_in[i*WIDTH +: WIDTH];
               end
               gain_q <= apical_gain;
               thr_q  <= ca_threshold;
               busy_q <= 1'b1;
               ch_q   <= '0;
            end
         end else begin
            out_valid_q   <= 1'b1;
            out_ch_q      <= ch_q;
            out_data_q    <= out_d;
            plat_q        <= (st_c == CA_PLATEAU);
            bac_q         <= bac_d;
            depot_q[ch_q] <= depot_d;
            ca_q[ch_q]    <= ca_d;
            st_q[ch_q]    <= st_d;
            cnt_q[ch_q]   <= cnt_d;
            win_q[ch_q]   <= win_d;
            if (ch_q == LAST_CH) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
               ch_q   <= '0;
            end else begin
               ch_q <= ch_q + 1'b1;
            end
         end
      end
   end

   assign busy           = busy_q;
   assign out_valid      = out_valid_q;
   assign out_ch         = out_ch_q;
   assign out_data       = out_data_q;
   assign out_ca_plateau = plat_q;
   assign out_bac        = bac_q;
   assign done           = done_q;
   assign overrun        = overrun_q;

endmodule

// File: tb/tb_dendritic_compartment_mc.sv
// Scoreboard bench for dendritic_compartment_mc: stimulus pushes model results, monitor pops on out_valid.
module tb_dendritic_compartment_mc;
   localparam int W      = 18;
   localparam int FRAC   = 14;
   localparam int N      = 4;
   localparam longint ONE     = 16384;
   localparam longint CABLE   = 410;
   localparam longint CA_A    = 137;
   localparam longint K_AP    = 4096;
   localparam longint K_BAC   = 24576;
   localparam longint BAC_T   = 4096;
   localparam int     PLAT    = 120;
   localparam int     REF     = 40;
   localparam int     BWIN    = 20;

   logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0, overrun_clr = 1'b0;
   logic [N*W-1:0] basal_in = '0, apical_in = '0;
   logic [W-1:0]   apical_gain = '0, ca_threshold = '0;
   logic busy, out_valid, out_ca_plateau, out_bac, done, overrun;
   logic [1:0]     out_ch;
   logic [W-1:0]   out_data;

   dendritic_compartment_mc dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
      .basal_in(basal_in), .apical_in(apical_in),
      .apical_gain(apical_gain), .ca_threshold(ca_threshold),
      .overrun_clr(overrun_clr), .busy(busy), .out_valid(out_valid),
      .out_ch(out_ch), .out_data(out_data), .out_ca_plateau(out_ca_plateau),
      .out_bac(out_bac), .done(done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      longint cyc;
      int     ch;
      longint data;
      bit     plat;
      bit     bac;
      bit     dn;
   } exp_t;
   exp_t q[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input longint act, input longint expv);
      n_checks++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
   endtask

   // Behavioural per-channel state: cable depot, Ca level, plateau phase, sweeps left, BAC window.
   longint m_dep[N], m_ca[N];
   int     m_phase[N], m_left[N], m_win[N];
   longint sb[N], sa[N], sg, sthr;

   function automatic longint wrapw(input longint x);
      longint y;
      y = x & 64'h3FFFF;
      if (y >= 131072) y -= 262144;
      return y;
   endfunction

   function automatic longint red(input longint x);
`ifdef DENDRITIC_MC_SATURATE_EN
      if (x > 131071)  return 131071;
      if (x < -131072) return -131072;
      return x;
`else
      return wrapw(x);
`endif
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_dep[k] = 0; m_ca[k] = 0; m_phase[k] = 0; m_left[k] = 0; m_win[k] = 0;
      end
   endtask

   task automatic push_sweep();
      longint c0, b, a, comb, o, cu;
      bit act, plat, bac;
      exp_t e;
      c0 = cyc;
      for (int k = 0; k < N; k++) begin
         b    = sb[k];
         a    = wrapw((sa[k] * sg) >>> FRAC);
         act  = (b > BAC_T) || (b < -BAC_T);
         plat = (m_phase[k] == 1);
         bac  = plat && (act || m_win[k] > 0);
         cu   = (m_ca[k] < 0) ? 0 : m_ca[k];
         comb = red(b + ((cu * K_AP) >>> FRAC));
         o    = red((comb * (bac ? K_BAC : ONE)) >>> FRAC);
         e.cyc = c0 + 2 + k; e.ch = k; e.data = o; e.plat = plat; e.bac = bac; e.dn = (k == N - 1);
         q.push_back(e);
         if (m_phase[k] == 0) begin
            if (m_dep[k] > sthr) begin m_phase[k] = 1; m_left[k] = PLAT; end
         end else begin
            m_left[k]--;
            if (m_left[k] == 0) begin
               if (m_phase[k] == 1) begin m_phase[k] = 2; m_left[k] = REF; end
               else m_phase[k] = 0;
            end
         end
         if (act) m_win[k] = BWIN;
         else if (m_win[k] > 0) m_win[k]--;
         m_dep[k] = wrapw(m_dep[k] + (((a - m_dep[k]) * CABLE) >>> FRAC));
         m_ca[k]  = wrapw(m_ca[k] + ((((plat ? ONE : 0) - m_ca[k]) * CA_A) >>> FRAC));
      end
   endtask

   task automatic drive_inputs();
      for (int k = 0; k < N; k++) begin
         basal_in[k*W +: W]  = sb[k][W-1:0];
         apical_in[k*W +: W] = sa[k][W-1:0];
      end
      apical_gain  = sg[W-1:0];
      ca_threshold = sthr[W-1:0];
   endtask

   // Called on a negedge; returns on the negedge where the next sweep may start.
   task automatic issue_sweep(input int ovr_at, input bit clr_too);
      drive_inputs();
      push_sweep();
      clk_en = 1'b1;
      @(negedge clk);
      clk_en = 1'b0;
      basal_in  = {$urandom, $urandom, $urandom};
      apical_in = {$urandom, $urandom, $urandom};
      apical_gain  = W'($urandom);
      ca_threshold = W'($urandom);
      for (int i = 1; i <= N; i++) begin
         if (i == ovr_at) begin clk_en = 1'b1; overrun_clr = clr_too; end
         @(negedge clk);
         clk_en = 1'b0;
         overrun_clr = 1'b0;
      end
   endtask

   task automatic zero_stim();
      for (int k = 0; k < N; k++) begin sb[k] = 0; sa[k] = 0; end
      sg = ONE; sthr = ONE;
   endtask

   task automatic rand_range(output longint v, input longint r);
      v = longint'($urandom_range(0, 32'(2 * r))) - r;
   endtask

   // Monitor: pops the scoreboard on every out_valid, also tracks run lengths for directed checks.
   int ch0_idx, first_plat, plat_run, plat_len0, bac_run, bac_len1;
   always @(negedge clk) begin
      if (!rst_n) begin
         ch0_idx = 0; first_plat = -1; plat_run = 0; plat_len0 = -1; bac_run = 0; bac_len1 = -1;
      end else if (out_valid) begin
         if (q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_valid: got ch %0d expected no output", out_ch);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("timing_cycle", cyc, e.cyc);
            chk("out_ch", longint'(out_ch), longint'(e.ch));
            chk("out_data", longint'($signed(out_data)), e.data);
            chk("out_ca_plateau", longint'(out_ca_plateau), longint'(e.plat));
            chk("out_bac", longint'(out_bac), longint'(e.bac));
            chk("done", longint'(done), longint'(e.dn));
            chk("busy_with_output", longint'(busy), longint'(!e.dn));
         end
         if (out_ch == 2'd0) begin
            if (out_ca_plateau) begin
               plat_run++;
               if (first_plat < 0) first_plat = ch0_idx;
            end else begin
               if (plat_run > 0 && plat_len0 < 0) plat_len0 = plat_run;
               plat_run = 0;
            end
            ch0_idx++;
         end
         if (out_ch == 2'd1) begin
            if (out_bac) bac_run++;
            else begin
               if (bac_run > 0 && bac_len1 < 0) bac_len1 = bac_run;
               bac_run = 0;
            end
         end
      end
   end

   task automatic reset_pulse();
      rst_n = 1'b0;
      q.delete();
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int t, nval;
      longint base[N], tbase, nz;
      model_reset();
      zero_stim();
      repeat (3) @(negedge clk);
      chk("reset_out_valid", longint'(out_valid), 0);
      chk("reset_busy", longint'(busy), 0);
      chk("reset_done", longint'(done), 0);
      chk("reset_overrun", longint'(overrun), 0);
      chk("reset_out_data", longint'(out_data), 0);
      chk("reset_out_bac", longint'(out_bac), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Passthrough: ch2 basal 0.5, no apical drive.
      zero_stim();
      sb[2] = 8192;
      issue_sweep(0, 1'b0);

      // Reset during channel 1 of a sweep.
      for (int k = 0; k < N; k++) begin rand_range(sb[k], ONE); rand_range(sa[k], ONE); end
      issue_sweep(0, 1'b0);
      drive_inputs();
      push_sweep();
      clk_en = 1'b1;
      @(negedge clk);
      clk_en = 1'b0;
      t = 0;
      while (!(out_valid && out_ch == 2'd1) && t < 10) begin @(negedge clk); t++; end
      chk("reset_wait_ch1", longint'(t < 10), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", longint'(out_valid), 0);
      chk("midreset_busy", longint'(busy), 0);
      chk("midreset_out_data", longint'(out_data), 0);
      chk("midreset_out_ch", longint'(out_ch), 0);
      q.delete();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      nval = 0;
      repeat (8) begin @(negedge clk); if (out_valid) nval++; end
      chk("no_valid_after_reset", nval, 0);
      for (int k = 0; k < N; k++) begin rand_range(sb[k], ONE); rand_range(sa[k], ONE); end
      issue_sweep(0, 1'b0);

      // Overrun: set by clk_en while busy, set wins over clear, clear alone clears.
      zero_stim();
      issue_sweep(2, 1'b0);
      chk("overrun_set", longint'(overrun), 1);
      issue_sweep(2, 1'b1);
      chk("overrun_set_wins", longint'(overrun), 1);
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      chk("overrun_cleared", longint'(overrun), 0);
      issue_sweep(0, 1'b0);
      chk("overrun_stays_clear", longint'(overrun), 0);

      // Plateau timing, BAC window and large basal on ch1 during the plateau.
      reset_pulse();
      zero_stim();
      sa[0] = ONE; sa[1] = ONE; sthr = 8192;
      for (int s = 0; s < 220; s++) begin
         sb[1] = (s == 60) ? 8192 : (s == 100) ? 131071 : 0;
         issue_sweep(0, 1'b0);
      end
      chk("plateau_entry_window", longint'(first_plat >= 26 && first_plat <= 31), 1);
      chk("plateau_length", plat_len0, PLAT);
      chk("bac_window_length", bac_len1, BWIN + 1);

      // Randomized sweeps with slowly varying per-channel drive.
      reset_pulse();
      for (int s = 0; s < 160; s++) begin
         if (s % 40 == 0) begin
            for (int k = 0; k < N; k++) rand_range(base[k], ONE);
            tbase = longint'($urandom_range(0, 8192));
            rand_range(sg, ONE);
            if (sg < 0) sg = -sg;
         end
         sthr = tbase;
         for (int k = 0; k < N; k++) begin
            rand_range(nz, 1024);
            sa[k] = base[k] + nz;
            if (sa[k] > ONE) sa[k] = ONE;
            if (sa[k] < -ONE) sa[k] = -ONE;
            if ($urandom_range(0, 3) == 0) rand_range(sb[k], 2 * ONE);
            else sb[k] = 0;
         end
         issue_sweep((s % 17 == 5) ? 3 : 0, 1'b0);
      end

      t = 0;
      while (q.size() != 0 && t < 20) begin @(negedge clk); t++; end
      if (q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
